axi4lite_rd_split_64to32: RTL and testbench
===========================================

# axi4lite_rd_split_64to32

Master-side read handler of the AXI4-Lite 64-to-32 bridge. It accepts one 64-bit read on the upstream (master-facing) AR/R channels and splits it into two sequential 32-bit reads, low word first. Each 32-bit read is launched by pulsing start to the downstream read slave driver, which owns the s_arvalid/s_rready handshakes. The block captures each returned half, merges the two responses, and returns a single 64-bit R beat upstream.

## Interface
- ADDR_W, 32: address width, upstream and downstream; minimum 4.
- ABORT_ON_ERR, 0: 1 = skip the high read when the low read returns SLVERR or DECERR.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_araddr  in  ADDR_W  upstream read address
- m_arvalid  in  1  upstream address valid
- m_arready  out  1  upstream address ready
- m_rdata  out  64  upstream read data, {hi, lo}
- m_rresp  out  2  upstream merged response
- m_rvalid  out  1  upstream read data valid
- m_rready  in  1  upstream read data ready
- s_araddr  out  ADDR_W  downstream 32-bit read address, registered
- s_rdata  in  32  downstream read data
- s_rresp  in  2  downstream read response
- drv_start  out  1  one-cycle launch pulse to the slave driver
- drv_done  in  1  slave driver completion; coincides with the downstream R handshake

## Operation
- States:
  - INIT: reset state; goes to IDLE unconditionally.
  - IDLE: m_arready=1; on m_arvalid, go to RD_LO.
  - RD_LO: drv_start=1; go to WAIT_LO.
  - WAIT_LO: wait for drv_done; then go to RD_HI, or to RESP on abort.
  - RD_HI: drv_start=1; go to WAIT_HI.
  - WAIT_HI: wait for drv_done; then go to RESP.
  - RESP: m_rvalid=1; on m_rready, go to IDLE.
- m_arready, drv_start and m_rvalid are decoded from the state register only. No input feeds them combinationally.
- On the AR handshake: base = {m_araddr[ADDR_W-1:3], 3'b000}, and s_araddr <= base. m_araddr[2:0] is ignored, so addresses are always 64-bit aligned.
- On drv_done in WAIT_LO: lo_data <= s_rdata, lo_resp <= s_rresp, s_araddr <= base | 4.
- On drv_done in WAIT_HI: hi_data <= s_rdata, hi_resp <= s_rresp.
- s_araddr holds stable from the drv_start cycle through the matching drv_done.
- Abort: if ABORT_ON_ERR=1 and lo_resp[1]=1, WAIT_LO goes to RESP. hi_data is forced to 0 and hi_resp to OKAY. No second drv_start is issued.
- Response merge, in priority order:
  - either response is DECERR (2'b11): DECERR;
  - else either is SLVERR (2'b10): SLVERR;
  - else OKAY (2'b00). EXOKAY is mapped to OKAY.
- m_rdata = {hi_data, lo_data} and m_rresp are held stable for the whole time m_rvalid=1.
- drv_done outside WAIT_LO/WAIT_HI is ignored; no state or data change.
- Exactly one drv_start pulse per half. There are no back-to-back pulses without an intervening drv_done.

## Timing
- Reset values:
  - state INIT;
  - m_arready, m_rvalid, drv_start = 0;
  - s_araddr, m_rdata, m_rresp = 0.
- m_arready first rises in the second cycle after rst_n deasserts (INIT, then IDLE).
- AR handshake at edge N gives drv_start=1 in cycle N+1.
- drv_done in cycle L (WAIT_LO) gives drv_start=1 in cycle L+1, with s_araddr = base|4 already valid.
- drv_done in cycle H (WAIT_HI) gives m_rvalid=1 in cycle H+1.
- Upstream handshake (m_rvalid & m_rready) at edge R gives m_arready=1 in cycle R+1.
- Minimum AR-to-R latency is 2 cycles plus the two slave driver round-trips.
- m_arready is 0 from the AR handshake until the cycle after the R handshake. Only one read is outstanding.
- Reset mid-operation: the block returns to INIT immediately, with no upstream response and pending halves discarded. The slave driver shares the same reset.

## Test plan
- Basic read:
  - Stimulus: m_araddr=0x1000; downstream returns 0x11111111 at 0x1000 and 0x22222222 at 0x1004, both OKAY.
  - Required: exactly two drv_start pulses, with s_araddr 0x1000 then 0x1004; m_rdata=0x22222222_11111111, m_rresp=OKAY.
- Unaligned address:
  - Stimulus: m_araddr=0x2006.
  - Required: s_araddr is 0x2000 then 0x2004.
- Response merge:
  - Stimulus: lo=SLVERR, hi=DECERR with ABORT_ON_ERR=0.
  - Required: m_rresp=DECERR after two reads.
  - Stimulus: lo=EXOKAY, hi=OKAY.
  - Required: m_rresp=OKAY.
- Abort:
  - Stimulus: ABORT_ON_ERR=1, lo returns SLVERR with data 0xDEADBEEF.
  - Required: only one drv_start; m_rdata=0x00000000_DEADBEEF, m_rresp=SLVERR.
- Upstream backpressure:
  - Stimulus: hold m_rready=0 for 5 cycles.
  - Required: m_rvalid stays 1 with stable data; m_arready=0 throughout; m_arready=1 the cycle after m_rready=1.
  - Stimulus: a spurious drv_done while in RESP.
  - Required: no effect.
- Reset:
  - Stimulus: assert rst_n low during WAIT_HI.
  - Required: all outputs 0 immediately; no m_rvalid; m_arready returns 2 cycles after release.

Source files
------------

// File: rtl/axi4lite_rd_split_64to32_if.sv
// rtl/axi4lite_rd_split_64to32_if.sv - upstream AR/R, downstream read and slave-driver signals of the 64-to-32 read splitter
interface axi4lite_rd_split_64to32_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [63:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;
    logic [ADDR_W-1:0] s_araddr;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              drv_start;
    logic              drv_done;

    modport master (
        output m_araddr, m_arvalid, m_rready, s_rdata, s_rresp, drv_done,
        input  m_arready, m_rdata, m_rresp, m_rvalid, s_araddr, drv_start
    );

    modport slave (
        input  m_araddr, m_arvalid, m_rready, s_rdata, s_rresp, drv_done,
        output m_arready, m_rdata, m_rresp, m_rvalid, s_araddr, drv_start
    );
endinterface

// File: rtl/axi4lite_rd_split_64to32.sv
// rtl/axi4lite_rd_split_64to32.sv - splits one 64-bit AXI4-Lite read into two 32-bit reads, low word first
module axi4lite_rd_split_64to32 #(
    parameter int ADDR_W       = 32,
    parameter bit ABORT_ON_ERR = 1'b0
) (
    input logic                           clk,
    input logic                           rst_n,
    axi4lite_rd_split_64to32_if.slave     bus
);
    typedef enum logic [2:0] {
        INIT, IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RESP
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] araddr_q;
    logic [31:0]       lo_data, hi_data;
    logic [1:0]        lo_resp, hi_resp;
    logic              abort;
    logic              unused_addr_lsb;

    // The low three address bits are dropped: every access is 64-bit aligned.
    assign unused_addr_lsb = ^bus.m_araddr[2:0];
    assign abort           = ABORT_ON_ERR && bus.s_rresp[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.m_arready = 1'b0;
        bus.drv_start = 1'b0;
        bus.m_rvalid  = 1'b0;
        case (state)
            INIT:    state_next = IDLE;
            IDLE: begin
                bus.m_arready = 1'b1;
                if (bus.m_arvalid) state_next = RD_LO;
            end
            RD_LO: begin
                bus.drv_start = 1'b1;
                state_next    = WAIT_LO;
            end
            WAIT_LO: if (bus.drv_done) state_next = abort ? RESP : RD_HI;
            RD_HI: begin
                bus.drv_start = 1'b1;
                state_next    = WAIT_HI;
            end
            WAIT_HI: if (bus.drv_done) state_next = RESP;
            RESP: begin
                bus.m_rvalid = 1'b1;
                if (bus.m_rready) state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q <= '0;
            lo_data  <= '0;
            lo_resp  <= 2'b00;
            hi_data  <= '0;
            hi_resp  <= 2'b00;
        end else begin
            case (state)
                IDLE: if (bus.m_arvalid) araddr_q <= {bus.m_araddr[ADDR_W-1:3], 3'b000};
                WAIT_LO: if (bus.drv_done) begin
                    lo_data  <= bus.s_rdata;
                    lo_resp  <= bus.s_rresp;
                    araddr_q <= {araddr_q[ADDR_W-1:3], 3'b100};
                    if (abort) begin
                        hi_data <= '0;
                        hi_resp <= 2'b00;
                    end
                end
                WAIT_HI: if (bus.drv_done) begin
                    hi_data <= bus.s_rdata;
                    hi_resp <= bus.s_rresp;
                end
                default: ;
            endcase
        end
    end

    // DECERR dominates SLVERR; EXOKAY collapses to OKAY.
    always_comb begin
        if (lo_resp == 2'b11 || hi_resp == 2'b11)      bus.m_rresp = 2'b11;
        else if (lo_resp == 2'b10 || hi_resp == 2'b10) bus.m_rresp = 2'b10;
        else                                           bus.m_rresp = 2'b00;
    end

    assign bus.s_araddr = araddr_q;
    assign bus.m_rdata  = {hi_data, lo_data};
endmodule

// File: tb/tb_axi4lite_rd_split_64to32.sv
// tb/tb_axi4lite_rd_split_64to32.sv - directed bench for the 64-to-32 read splitter, with and without abort-on-error
module tb_axi4lite_rd_split_64to32;
    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        rready;
    logic [31:0] rdata_in;
    logic [1:0]  rresp_in;
    logic        done;

    int tests = 0;
    int fails = 0;
    int starts0 = 0;
    int starts1 = 0;
    int base0, base1;

    logic [31:0] obs_lo_addr, obs_hi_addr;
    logic        obs_lo_start, obs_hi_start;
    logic        obs1_early_rvalid, obs1_hi_start;

    axi4lite_rd_split_64to32_if #(.ADDR_W(32)) bif0 ();
    axi4lite_rd_split_64to32_if #(.ADDR_W(32)) bif1 ();

    assign bif0.m_araddr  = araddr;
    assign bif0.m_arvalid = arvalid;
    assign bif0.m_rready  = rready;
    assign bif0.s_rdata   = rdata_in;
    assign bif0.s_rresp   = rresp_in;
    assign bif0.drv_done  = done;
    assign bif1.m_araddr  = araddr;
    assign bif1.m_arvalid = arvalid;
    assign bif1.m_rready  = rready;
    assign bif1.s_rdata   = rdata_in;
    assign bif1.s_rresp   = rresp_in;
    assign bif1.drv_done  = done;

    axi4lite_rd_split_64to32 #(.ADDR_W(32), .ABORT_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bif0.slave));
    axi4lite_rd_split_64to32 #(.ADDR_W(32), .ABORT_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bif1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bif0.drv_start) starts0 <= starts0 + 1;
        if (bif1.drv_start) starts1 <= starts1 + 1;
    end

    // Drives one full read up to the RESP state of dut0; records observations only.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] lo_d, input logic [1:0] lo_r,
                           input logic [31:0] hi_d, input logic [1:0] hi_r);
        base0 = starts0;
        base1 = starts1;
        @(posedge clk); #1 araddr = addr; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        obs_lo_addr  = bif0.s_araddr;
        obs_lo_start = bif0.drv_start;
        @(posedge clk);
        @(posedge clk); #1 done = 1'b1; rdata_in = lo_d; rresp_in = lo_r;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        obs_hi_addr       = bif0.s_araddr;
        obs_hi_start      = bif0.drv_start;
        obs1_early_rvalid = bif1.m_rvalid;
        obs1_hi_start     = bif1.drv_start;
        @(posedge clk);
        @(posedge clk); #1 done = 1'b1; rdata_in = hi_d; rresp_in = hi_r;
        @(posedge clk); #1 done = 1'b0;
    endtask

    task automatic finish_resp();
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bif0.m_arready !== 1'b0) begin fails++; $display("FAIL rst_arready: got %b want 0", bif0.m_arready); end
        tests++; if (bif0.m_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b want 0", bif0.m_rvalid); end
        tests++; if (bif0.drv_start !== 1'b0) begin fails++; $display("FAIL rst_drv_start: got %b want 0", bif0.drv_start); end
        tests++; if (bif0.s_araddr !== 32'h0) begin fails++; $display("FAIL rst_s_araddr: got %h want 0", bif0.s_araddr); end
        tests++; if (bif0.m_rdata !== 64'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", bif0.m_rdata); end
        tests++; if (bif0.m_rresp !== 2'b00) begin fails++; $display("FAIL rst_rresp: got %b want 0", bif0.m_rresp); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        tests++; if (bif0.m_arready !== 1'b0) begin fails++; $display("FAIL rst_init_cycle: arready got %b want 0", bif0.m_arready); end
        @(negedge clk);
        tests++; if (bif0.m_arready !== 1'b1) begin fails++; $display("FAIL rst_idle_cycle: arready got %b want 1", bif0.m_arready); end
    endtask

    task automatic test_basic();
        do_read(32'h1000, 32'h1111_1111, 2'b00, 32'h2222_2222, 2'b00);
        tests++; if (obs_lo_start !== 1'b1) begin fails++; $display("FAIL basic_start_lo: got %b want 1", obs_lo_start); end
        tests++; if (obs_lo_addr !== 32'h1000) begin fails++; $display("FAIL basic_addr_lo: got %h want 00001000", obs_lo_addr); end
        tests++; if (obs_hi_start !== 1'b1) begin fails++; $display("FAIL basic_start_hi: got %b want 1", obs_hi_start); end
        tests++; if (obs_hi_addr !== 32'h1004) begin fails++; $display("FAIL basic_addr_hi: got %h want 00001004", obs_hi_addr); end
        @(negedge clk);
        tests++; if (bif0.m_rvalid !== 1'b1) begin fails++; $display("FAIL basic_rvalid: got %b want 1", bif0.m_rvalid); end
        tests++; if (bif0.m_rdata !== 64'h2222_2222_1111_1111) begin fails++; $display("FAIL basic_rdata: got %h want 2222222211111111", bif0.m_rdata); end
        tests++; if (bif0.m_rresp !== 2'b00) begin fails++; $display("FAIL basic_rresp: got %b want 00", bif0.m_rresp); end
        tests++; if (bif0.m_arready !== 1'b0) begin fails++; $display("FAIL basic_arready_busy: got %b want 0", bif0.m_arready); end
        tests++; if (bif1.m_rdata !== 64'h2222_2222_1111_1111) begin fails++; $display("FAIL basic_rdata_abortcfg: got %h want 2222222211111111", bif1.m_rdata); end
        finish_resp();
        @(negedge clk);
        tests++; if (bif0.m_arready !== 1'b1) begin fails++; $display("FAIL basic_arready_after: got %b want 1", bif0.m_arready); end
        tests++; if (bif0.m_rvalid !== 1'b0) begin fails++; $display("FAIL basic_rvalid_after: got %b want 0", bif0.m_rvalid); end
        tests++; if (starts0 - base0 !== 2) begin fails++; $display("FAIL basic_start_count: got %0d want 2", starts0 - base0); end
    endtask

    task automatic test_unaligned_exokay();
        do_read(32'h2006, 32'hA5A5_0001, 2'b01, 32'h5A5A_0002, 2'b00);
        tests++; if (obs_lo_addr !== 32'h2000) begin fails++; $display("FAIL unal_addr_lo: got %h want 00002000", obs_lo_addr); end
        tests++; if (obs_hi_addr !== 32'h2004) begin fails++; $display("FAIL unal_addr_hi: got %h want 00002004", obs_hi_addr); end
        @(negedge clk);
        tests++; if (bif0.m_rresp !== 2'b00) begin fails++; $display("FAIL exokay_rresp: got %b want 00", bif0.m_rresp); end
        tests++; if (bif0.m_rdata !== 64'h5A5A_0002_A5A5_0001) begin fails++; $display("FAIL exokay_rdata: got %h want 5a5a0002a5a50001", bif0.m_rdata); end
        finish_resp();
    endtask

    task automatic test_merge_abort();
        do_read(32'h3000, 32'hDEAD_BEEF, 2'b10, 32'hCAFE_F00D, 2'b11);
        tests++; if (obs1_early_rvalid !== 1'b1) begin fails++; $display("FAIL abort_early_rvalid: got %b want 1", obs1_early_rvalid); end
        tests++; if (obs1_hi_start !== 1'b0) begin fails++; $display("FAIL abort_no_hi_start: got %b want 0", obs1_hi_start); end
        @(negedge clk);
        tests++; if (bif0.m_rresp !== 2'b11) begin fails++; $display("FAIL merge_rresp: got %b want 11", bif0.m_rresp); end
        tests++; if (bif0.m_rdata !== 64'hCAFE_F00D_DEAD_BEEF) begin fails++; $display("FAIL merge_rdata: got %h want cafef00ddeadbeef", bif0.m_rdata); end
        tests++; if (bif1.m_rresp !== 2'b10) begin fails++; $display("FAIL abort_rresp: got %b want 10", bif1.m_rresp); end
        tests++; if (bif1.m_rdata !== 64'h0000_0000_DEAD_BEEF) begin fails++; $display("FAIL abort_rdata: got %h want 00000000deadbeef", bif1.m_rdata); end
        tests++; if (bif1.m_rvalid !== 1'b1) begin fails++; $display("FAIL abort_rvalid: got %b want 1", bif1.m_rvalid); end
        finish_resp();
        @(negedge clk);
        tests++; if (starts0 - base0 !== 2) begin fails++; $display("FAIL merge_start_count: got %0d want 2", starts0 - base0); end
        tests++; if (starts1 - base1 !== 1) begin fails++; $display("FAIL abort_start_count: got %0d want 1", starts1 - base1); end
        tests++; if (bif1.m_arready !== 1'b1) begin fails++; $display("FAIL abort_arready_after: got %b want 1", bif1.m_arready); end
    endtask

    task automatic test_backpressure();
        do_read(32'h400C, 32'h0BAD_F00D, 2'b00, 32'h1234_5678, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (bif0.m_rvalid !== 1'b1) begin fails++; $display("FAIL bp_rvalid[%0d]: got %b want 1", i, bif0.m_rvalid); end
            tests++; if (bif0.m_rdata !== 64'h1234_5678_0BAD_F00D) begin fails++; $display("FAIL bp_rdata[%0d]: got %h want 123456780badf00d", i, bif0.m_rdata); end
            tests++; if (bif0.m_rresp !== 2'b00) begin fails++; $display("FAIL bp_rresp[%0d]: got %b want 00", i, bif0.m_rresp); end
            tests++; if (bif0.m_arready !== 1'b0) begin fails++; $display("FAIL bp_arready[%0d]: got %b want 0", i, bif0.m_arready); end
            if (i == 2) begin done = 1'b1; rdata_in = 32'hFFFF_FFFF; rresp_in = 2'b11; end
            if (i == 3) done = 1'b0;
        end
        finish_resp();
        @(negedge clk);
        tests++; if (bif0.m_arready !== 1'b1) begin fails++; $display("FAIL bp_arready_after: got %b want 1", bif0.m_arready); end
        tests++; if (bif0.m_rdata !== 64'h1234_5678_0BAD_F00D) begin fails++; $display("FAIL spurious_done_rdata: got %h want 123456780badf00d", bif0.m_rdata); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 araddr = 32'h5000; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 done = 1'b1; rdata_in = 32'h7777_7777; rresp_in = 2'b00;
        @(posedge clk); #1 done = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        tests++; if (bif0.s_araddr !== 32'h0) begin fails++; $display("FAIL midrst_s_araddr: got %h want 0", bif0.s_araddr); end
        tests++; if (bif0.m_rdata !== 64'h0) begin fails++; $display("FAIL midrst_rdata: got %h want 0", bif0.m_rdata); end
        tests++; if ({bif0.m_arready, bif0.m_rvalid, bif0.drv_start} !== 3'b000) begin
            fails++; $display("FAIL midrst_ctrl: got %b want 000", {bif0.m_arready, bif0.m_rvalid, bif0.drv_start}); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({bif0.m_arready, bif0.m_rvalid} !== 2'b00) begin fails++; $display("FAIL midrst_init: got %b want 00", {bif0.m_arready, bif0.m_rvalid}); end
        @(negedge clk);
        tests++; if ({bif0.m_arready, bif0.m_rvalid} !== 2'b10) begin fails++; $display("FAIL midrst_idle: got %b want 10", {bif0.m_arready, bif0.m_rvalid}); end
    endtask

    initial begin
        rst_n    = 1'b0;
        araddr   = '0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        rdata_in = '0;
        rresp_in = 2'b00;
        done     = 1'b0;
        test_reset();
        test_basic();
        test_unaligned_exokay();
        test_merge_abort();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
